// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_SRC byte-stream sources.
// A grant covers a whole packet and is revoked only by src_last completion or a stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int TIMEOUT_CLK = 50_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_req,
    input  logic                 uart_tx_done
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int CNT_W = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLK - 1);

    typedef enum logic [1:0] {
        S0_IDLE,
        S1_LOAD,
        S2_SEND
    } state_t;

    state_t                    state, state_d;
    logic [PTR_W-1:0]          ptr, ptr_d, win;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic                      last_q, last_d;
    logic                      any_valid;
    logic [NUM_SRC-1:0]        grant_d, ready_d;
    logic [7:0]                data_d;
    logic                      req_d, terr_d;
    logic [NUM_SRC-1:0][7:0]   src_bytes;

    assign src_bytes = src_data;

    // Source index k steps after p, wrapping modulo NUM_SRC.
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p, input int k);
        int v;
        v = int'(p) + k;
        if (v >= NUM_SRC) v = v - NUM_SRC;
        return PTR_W'(v);
    endfunction

    // Scan from farthest to nearest so the closest valid source after ptr wins.
    always_comb begin
        win       = ptr;
        any_valid = |src_valid;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (src_valid[nxt(ptr, k)]) win = nxt(ptr, k);
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        last_d  = last_q;
        grant_d = grant;
        data_d  = uart_tx_data;
        req_d   = 1'b0;
        ready_d = '0;
        terr_d  = 1'b0;
        unique case (state)
            S0_IDLE: begin
                if (any_valid) begin
                    ptr_d   = win;
                    grant_d = NUM_SRC'(1) << win;
                    cnt_d   = '0;
                    state_d = S1_LOAD;
                end
            end
            S1_LOAD: begin
                if (src_valid[ptr]) begin
                    data_d  = src_bytes[ptr];
                    last_d  = src_last[ptr];
                    req_d   = 1'b1;
                    ready_d = NUM_SRC'(1) << ptr;
                    state_d = S2_SEND;
                end else if (cnt == CNT_MAX) begin
                    terr_d  = 1'b1;
                    grant_d = '0;
                    state_d = S0_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S2_SEND: begin
                if (uart_tx_done) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = S0_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S1_LOAD;
                    end
                end
            end
            default: state_d = S0_IDLE;
        endcase
    end

    // Every output is a flop; busy tracks the next state so it equals state != S0_IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= S0_IDLE;
            ptr          <= PTR_RST;
            cnt          <= '0;
            last_q       <= 1'b0;
            grant        <= '0;
            busy         <= 1'b0;
            src_ready    <= '0;
            timeout_err  <= 1'b0;
            uart_tx_data <= 8'h00;
            uart_tx_req  <= 1'b0;
        end else begin
            state        <= state_d;
            ptr          <= ptr_d;
            cnt          <= cnt_d;
            last_q       <= last_d;
            grant        <= grant_d;
            busy         <= (state_d != S0_IDLE);
            src_ready    <= ready_d;
            timeout_err  <= terr_d;
            uart_tx_data <= data_d;
            uart_tx_req  <= req_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued byte sources, a fixed-latency uart_tx
// responder and a req/grant log checked against hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int NS = 4;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS-1:0]     src_valid = '0;
    logic [8*NS-1:0]   src_data = '0;
    logic [NS-1:0]     src_last = '0;
    logic [NS-1:0]     src_ready;
    logic [NS-1:0]     grant;
    logic              busy;
    logic              timeout_err;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_req;
    logic              uart_tx_done;

    uart_tx_arbiter #(.NUM_SRC(NS), .TIMEOUT_CLK(TO)) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .grant        (grant),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .uart_tx_data (uart_tx_data),
        .uart_tx_req  (uart_tx_req),
        .uart_tx_done (uart_tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // uart_tx stand-in: done is sampled by the DUT 3 edges after the req cycle.
    int   tx_cnt = 0;
    logic done_inj = 1'b0;
    assign uart_tx_done = (tx_cnt == 1) | done_inj;
    always @(negedge clk) begin
        if (uart_tx_req) tx_cnt = 3;
        else if (tx_cnt != 0) tx_cnt = tx_cnt - 1;
    end

    // Per-source byte queues {last, data}; next byte is presented as soon as ready is seen.
    logic [8:0] sbuf [NS][64];
    int rd [NS] = '{default: 0};
    int wr [NS] = '{default: 0};
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (src_ready[i] && rd[i] < wr[i]) rd[i]++;
            src_valid[i]       = (rd[i] < wr[i]);
            src_data[8*i +: 8] = sbuf[i][rd[i]][7:0];
            src_last[i]        = sbuf[i][rd[i]][8];
        end
    end

    // Log of every uart_tx_req, grant change, timeout pulse and ready pulse.
    logic [7:0]    lg_data  [256];
    logic [NS-1:0] lg_grant [256];
    int            lg_cyc   [256];
    int            lg_n = 0;
    logic [NS-1:0] gch_val  [256];
    int            gch_cyc  [256];
    int            gch_n = 0;
    logic [NS-1:0] prev_grant = '0;
    int            terr_n = 0;
    int            terr_cyc = 0;
    logic [NS-1:0] terr_grant = '0;
    int            rdy_n [NS] = '{default: 0};
    always @(negedge clk) begin
        if (uart_tx_req) begin
            lg_data[lg_n]  = uart_tx_data;
            lg_grant[lg_n] = grant;
            lg_cyc[lg_n]   = cyc;
            lg_n++;
        end
        if (grant != prev_grant) begin
            gch_val[gch_n] = grant;
            gch_cyc[gch_n] = cyc;
            gch_n++;
            prev_grant = grant;
        end
        if (timeout_err) begin
            terr_n++;
            terr_cyc   = cyc;
            terr_grant = grant;
        end
        for (int i = 0; i < NS; i++) if (src_ready[i]) rdy_n[i]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic last);
        sbuf[s][wr[s]] = {last, d};
        wr[s]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NS; i++) if (rd[i] < wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int max);
        bit ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            tick();
            if (!busy && all_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int target, input int max);
        bit ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            tick();
            if (lg_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, gbase, tbase, r0;
        bit ok;

        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req", 32'(uart_tx_req), 32'h0);
        chk("rst_ready", 32'(src_ready), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        chk("rst_data", 32'(uart_tx_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: "OK\r\n" from source 0
        base = lg_n;
        r0   = rdy_n[0];
        push(0, 8'h4F, 1'b0);
        push(0, 8'h4B, 1'b0);
        push(0, 8'h0D, 1'b0);
        push(0, 8'h0A, 1'b1);
        tick();
        chk("t1_grant_lat", 32'(grant), 32'h1);
        chk("t1_req_early", 32'(uart_tx_req), 32'h0);
        tick();
        chk("t1_req_lat", 32'(uart_tx_req), 32'h1);
        chk("t1_ready_lat", 32'(src_ready), 32'h1);
        chk("t1_data0", 32'(uart_tx_data), 32'h4F);
        wait_idle("t1_idle", 200);
        chk("t1_nbytes", 32'(lg_n - base), 32'd4);
        chk("t1_bytes", {lg_data[base], lg_data[base+1], lg_data[base+2], lg_data[base+3]}, 32'h4F4B0D0A);
        for (int k = 0; k < 4; k++) chk("t1_grant_hold", 32'(lg_grant[base+k]), 32'h1);
        chk("t1_gap", 32'(lg_cyc[base+1] - lg_cyc[base]), 32'd4);
        chk("t1_ready_cnt", 32'(rdy_n[0] - r0), 32'd4);
        chk("t1_grant_end", 32'(grant), 32'h0);

        // 2: all sources hold 1-byte packets -> round-robin 0,1,2,3,0,1,2,3
        pulse_reset();
        base = lg_n;
        for (int i = 0; i < NS; i++) begin
            push(i, 8'(8'h10 + i), 1'b1);
            push(i, 8'(8'h20 + i), 1'b1);
        end
        wait_idle("t2_idle", 400);
        chk("t2_n", 32'(lg_n - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_grant", 32'(lg_grant[base+k]), 32'(1 << (k % 4)));
            chk("t2_data", 32'(lg_data[base+k]), (k < 4) ? 32'(8'h10 + k) : 32'(8'h20 + k - 4));
        end

        // 3: source 1 arrives mid-packet of source 0
        pulse_reset();
        base  = lg_n;
        gbase = gch_n;
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b0);
        push(0, 8'hA3, 1'b1);
        wait_log("t3_first", base + 1, 50);
        push(1, 8'hB1, 1'b1);
        wait_idle("t3_idle", 300);
        chk("t3_order", {lg_data[base], lg_data[base+1], lg_data[base+2], lg_data[base+3]}, 32'hA1A2A3B1);
        chk("t3_b1_grant", 32'(lg_grant[base+3]), 32'h2);
        chk("t3_g0", 32'(gch_val[gbase]), 32'h1);
        chk("t3_g_release", 32'(gch_val[gbase+1]), 32'h0);
        chk("t3_g_src1", 32'(gch_val[gbase+2]), 32'h2);
        chk("t3_idle_gap", 32'(gch_cyc[gbase+2] - gch_cyc[gbase+1]), 32'd1);

        // 4: source 0 stalls after 8'h41, source 2 waits
        pulse_reset();
        base  = lg_n;
        tbase = terr_n;
        push(0, 8'h41, 1'b0);
        wait_log("t4_first", base + 1, 50);
        push(2, 8'h42, 1'b1);
        repeat (20) tick();
        chk("t4_hold", 32'(grant), 32'h1);
        wait_idle("t4_idle", 400);
        chk("t4_terr_cnt", 32'(terr_n - tbase), 32'd1);
        // req cycle + 3 to reach S1_LOAD, then TIMEOUT_CLK clocks in S1_LOAD
        chk("t4_terr_time", 32'(terr_cyc - lg_cyc[base]), 32'(3 + TO));
        chk("t4_terr_grant", 32'(terr_grant), 32'h0);
        chk("t4_n", 32'(lg_n - base), 32'd2);
        chk("t4_src2_data", 32'(lg_data[base+1]), 32'h42);
        chk("t4_src2_grant", 32'(lg_grant[base+1]), 32'h4);
        chk("t4_src2_lat", 32'(lg_cyc[base+1] - terr_cyc), 32'd2);

        // 5: asynchronous reset during S2_SEND
        pulse_reset();
        base = lg_n;
        push(3, 8'h55, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (uart_tx_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_req_seen", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_req", 32'(uart_tx_req), 32'h0);
        chk("t5_rst_ready", 32'(src_ready), 32'h0);
        wr[3] = rd[3];
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("t5_no_req", 32'(lg_n - base), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'h0);

        // 6: stray uart_tx_done in S0_IDLE and in S1_LOAD
        base  = lg_n;
        tbase = terr_n;
        done_inj = 1'b1;
        tick();
        done_inj = 1'b0;
        tick();
        chk("t6_idle_busy", 32'(busy), 32'h0);
        chk("t6_idle_noreq", 32'(lg_n - base), 32'd0);
        push(1, 8'h61, 1'b0);
        wait_log("t6_first", base + 1, 50);
        repeat (8) tick();
        chk("t6_load_grant", 32'(grant), 32'h2);
        done_inj = 1'b1;
        tick();
        done_inj = 1'b0;
        repeat (3) tick();
        chk("t6_load_busy", 32'(busy), 32'h1);
        chk("t6_load_grant2", 32'(grant), 32'h2);
        chk("t6_load_noreq", 32'(lg_n - base), 32'd1);
        push(1, 8'h62, 1'b1);
        wait_idle("t6_idle", 200);
        chk("t6_n", 32'(lg_n - base), 32'd2);
        chk("t6_bytes", {16'h0, lg_data[base], lg_data[base+1]}, 32'h6162);
        chk("t6_grant", 32'(lg_grant[base+1]), 32'h2);
        chk("t6_no_terr", 32'(terr_n - tbase), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
